// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and the shared 8-to-1 mux arbiter.
// The arbiter side uses the slave modport; the requester side uses master.
interface mux8_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;

    modport master (
        output req,
        input  gnt,
        input  sel,
        input  valid
    );

    modport slave (
        input  req,
        output gnt,
        output sel,
        output valid
    );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter owning the select {c,b,a} of an 8-to-1 mux; grants are
// bounded by MAX_HOLD and separated by a one-cycle bubble.
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mux8_rr_arbiter_if.slave   bus
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];

    logic [0:0] state_r;
    logic [2:0] ptr_r;
    logic [2:0] owner_r;
    logic [7:0] hold_cnt_r;
    logic [7:0] gnt_r;
    logic [2:0] sel_r;
    logic       valid_r;

    logic [7:0] rot_s;
    logic [2:0] win_s;

    // Lowest set bit of a vector; only meaningful when the vector is non-zero.
    function automatic logic [2:0] first_set(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Rotate requests so ptr_r is bit 0, then map the first hit back to an absolute index.
    always_comb begin
        rot_s = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rot_s[i] = bus.req[ptr_r + 3'(i)];
        end
        win_s = ptr_r + first_set(rot_s);
    end

    // Arbitration FSM; all outputs are flops, sel keeps the last owner while idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            ptr_r      <= 3'd0;
            owner_r    <= 3'd0;
            hold_cnt_r <= 8'd0;
            gnt_r      <= 8'h00;
            sel_r      <= 3'd0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|bus.req) begin
                        owner_r    <= win_s;
                        gnt_r      <= 8'd1 << win_s;
                        sel_r      <= win_s;
                        valid_r    <= 1'b1;
                        hold_cnt_r <= 8'd1;
                        state_r    <= GRANT;
                    end else begin
                        gnt_r   <= 8'h00;
                        valid_r <= 1'b0;
                    end
                end
                GRANT: begin
                    if (bus.req[owner_r] && (hold_cnt_r < MAX_HOLD_C)) begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end else begin
                        // Voluntary release or timeout: old owner drops to lowest priority.
                        gnt_r      <= 8'h00;
                        valid_r    <= 1'b0;
                        ptr_r      <= owner_r + 3'd1;
                        hold_cnt_r <= 8'd0;
                        state_r    <= IDLE;
                    end
                end
                default: begin
                    gnt_r      <= 8'h00;
                    valid_r    <= 1'b0;
                    hold_cnt_r <= 8'd0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.sel   = sel_r;
    assign bus.valid = valid_r;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench: a vector table on a MAX_HOLD=16 instance, plus rotation
// (MAX_HOLD=4) and sole-requester timeout (MAX_HOLD=3) sequences.
module tb_mux8_rr_arbiter;

    logic clk;
    logic rst_n;

    mux8_rr_arbiter_if if16 ();
    mux8_rr_arbiter_if if4 ();
    mux8_rr_arbiter_if if3 ();

    mux8_rr_arbiter #(.MAX_HOLD(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    mux8_rr_arbiter #(.MAX_HOLD(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    mux8_rr_arbiter #(.MAX_HOLD(3))  dut3  (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] exp_gnt;
        logic [2:0] exp_sel;
        logic       exp_valid;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [7:0] g, input logic [2:0] s, input logic v,
                         input logic [7:0] eg, input logic [2:0] es, input logic ev);
        checks++;
        if (g !== eg || s !== es || v !== ev) begin
            errors++;
            $display("FAIL %s: got gnt=%h sel=%0d valid=%b, expected gnt=%h sel=%0d valid=%b",
                     name, g, s, v, eg, es, ev);
        end
    endtask

    initial begin
        logic [7:0] eg;
        logic [2:0] es;
        logic       ev;
        int         k;

        // rst_n, req, expected gnt/sel/valid after the edge
        vecs[0]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 8'h01, 3'd0, 1'b1};
        vecs[4]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        vecs[6]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[7]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[8]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[9]  = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[10] = '{1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        vecs[11] = '{1'b1, 8'h00, 8'h00, 3'd5, 1'b0};
        vecs[12] = '{1'b1, 8'h00, 8'h00, 3'd5, 1'b0};
        vecs[13] = '{1'b1, 8'h40, 8'h40, 3'd6, 1'b1};
        vecs[14] = '{1'b1, 8'h00, 8'h00, 3'd6, 1'b0};
        vecs[15] = '{1'b1, 8'h09, 8'h01, 3'd0, 1'b1};
        vecs[16] = '{1'b1, 8'h09, 8'h01, 3'd0, 1'b1};
        vecs[17] = '{1'b1, 8'h08, 8'h00, 3'd0, 1'b0};
        vecs[18] = '{1'b1, 8'h09, 8'h08, 3'd3, 1'b1};
        vecs[19] = '{1'b1, 8'hF8, 8'h08, 3'd3, 1'b1};
        vecs[20] = '{1'b0, 8'h08, 8'h00, 3'd0, 1'b0};
        vecs[21] = '{1'b1, 8'h08, 8'h08, 3'd3, 1'b1};
        vecs[22] = '{1'b1, 8'h00, 8'h00, 3'd3, 1'b0};

        rst_n    = 1'b0;
        if16.req = 8'h00;
        if4.req  = 8'h00;
        if3.req  = 8'h00;

        for (int i = 0; i < NVEC; i++) begin
            rst_n    = vecs[i].rst_n;
            if16.req = vecs[i].req;
            tick();
            check($sformatf("vec%0d", i), if16.gnt, if16.sel, if16.valid,
                  vecs[i].exp_gnt, vecs[i].exp_sel, vecs[i].exp_valid);
        end

        // Full rotation, MAX_HOLD=4: 4 grant cycles + 1 bubble per owner.
        rst_n   = 1'b0;
        if4.req = 8'hFF;
        tick();
        check("rot_reset", if4.gnt, if4.sel, if4.valid, 8'h00, 3'd0, 1'b0);
        rst_n = 1'b1;
        for (int c = 1; c <= 45; c++) begin
            tick();
            k  = (c - 1) % 5;
            es = 3'((c - 1) / 5);
            if (k < 4) begin
                eg = 8'd1 << es;
                ev = 1'b1;
            end else begin
                eg = 8'h00;
                ev = 1'b0;
            end
            check($sformatf("rot_c%0d", c), if4.gnt, if4.sel, if4.valid, eg, es, ev);
        end
        if4.req = 8'h00;

        // Sole requester timeout, MAX_HOLD=3: 3 grant cycles + 1 bubble, sel stays 2.
        rst_n   = 1'b0;
        if3.req = 8'h04;
        tick();
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            k = (c - 1) % 4;
            if (k < 3) begin
                eg = 8'h04;
                ev = 1'b1;
            end else begin
                eg = 8'h00;
                ev = 1'b0;
            end
            check($sformatf("tmo_c%0d", c), if3.gnt, if3.sel, if3.valid, eg, 3'd2, ev);
        end
        if3.req = 8'h00;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

Round-robin arbiter that shares the 8-to-1 data multiplexer among eight requesters. Each requester asserts a request line. The arbiter grants exactly one owner at a time and drives the mux select {c,b,a} with that owner's index, so the owner's data reaches the single mux output. Hold time is bounded and fairness is guaranteed by a rotating priority pointer.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  8  request vector; req[i] high means requester i wants the mux.
- gnt  output  8  one-hot grant, registered; all-zero when no owner.
- sel  output  3  mux select index of the current or last owner; drives {c,b,a}, with sel[2]=c, sel[1]=b, sel[0]=a.
- valid  output  1  high while gnt is non-zero; qualifies the mux output.

## Operation
- States: IDLE and GRANT. Internal registers:
  - ptr[2:0]: highest-priority index.
  - owner[2:0]: current owner index.
  - hold_cnt[7:0]: cycles the current owner has held the grant.
- Reset (rst_n=0 at a clock edge) sets:
  - state=IDLE, ptr=0, owner=0, hold_cnt=0
  - gnt=8'h00, sel=3'd0, valid=0
- Reset overrides everything, including mid-grant; outputs clear at that edge.
- IDLE behaviour:
  - If req==0: stay in IDLE, gnt=0, valid=0, sel holds its last value so the mux does not toggle.
  - Otherwise: pick the first set bit searching ptr, ptr+1, … ptr+7 (mod 8).
  - At the next edge: owner=winner, gnt=1<<winner, sel=winner, valid=1, hold_cnt=1, state=GRANT.
- GRANT behaviour: stay while req[owner]=1 and hold_cnt<MAX_HOLD; increment hold_cnt each cycle.
- Release happens when either condition is sampled:
  - req[owner]=0 (voluntary release), or
  - req[owner]=1 with hold_cnt==MAX_HOLD (timeout).
- At the release edge:
  - gnt=0, valid=0, sel unchanged
  - ptr=owner+1 (mod 8, so 7 wraps to 0)
  - hold_cnt=0, state=IDLE
- After a timeout the previous owner is lowest priority. If it is the only requester, it is re-granted after the bubble cycle.
- Changes to req bits other than req[owner] during GRANT have no effect until the next arbitration.
- gnt is always one-hot or zero. valid == |gnt at every cycle. sel == index of the set bit whenever valid=1.

## Timing
- Arbitration latency: req sampled at edge N produces the grant after edge N. The grant is visible in the cycle after request assertion (1 cycle).
- Release latency: req[owner] deasserted before edge N makes gnt/valid low after edge N.
- Mandatory one-cycle bubble (valid=0) between consecutive grants. The bubble lets downstream logic see a clean ownership change; no back-to-back grants occur.
- Maximum continuous grant: MAX_HOLD cycles. With MAX_HOLD=1, each grant lasts exactly 1 cycle followed by 1 bubble.
- Worst-case wait for a requester holding req high: 7×(MAX_HOLD+1)+1 cycles.
- All outputs are driven directly from flops; there is no combinational path from req to any output.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with req=8'hFF → gnt=8'h00, sel=0, valid=0 every cycle. Release reset → gnt=8'h01, sel=0, valid=1 one cycle later.
- Single requester: req=8'h20 from cycle 0, dropped at cycle 5, MAX_HOLD=16 → gnt=8'h20, sel=5, valid=1 for cycles 1–5. gnt=0 and valid=0 from cycle 6. sel stays 5.
- Full rotation: req=8'hFF constant, MAX_HOLD=4 → owners 0,1,2,…,7,0 in order. Each grant lasts 4 cycles and is followed by exactly 1 bubble (period 5). sel matches the owner each time.
- Wrap-around priority: after owner 6 releases (ptr=7), apply req=8'h09 → requester 0 is granted before requester 3. Requester 3 is granted after 0 releases plus the bubble.
- Timeout sole requester: MAX_HOLD=3, req=8'h04 constant → pattern of gnt=8'h04 for 3 cycles, then 1 bubble, repeating; sel=2 throughout.
- Reset mid-grant: owner 3 granted, assert rst_n=0 for one edge → gnt=0, sel=0, valid=0 at that edge. With req=8'h08 still high, gnt=8'h08 returns one cycle after rst_n=1.
